// File: rtl/uart_rx_axis.sv
// ---------------------------------------------------------------------------
// uart_rx_axis
//
// Parametrised UART receiver with an AXI4-Stream master output. Successor to
// the fixed 8N1 receiver: configurable data width, parity and stop bits,
// false-start rejection, parity/framing error flags on tuser and a
// first-word-fall-through receive FIFO with overrun reporting.
//
// Optional build macro:
//   UART_RX_MAJORITY_EN - each bit is the 2-of-3 majority of the synchronised
//                         line at baud_cnt == H-1, H, H+1 (decision at H+1).
//                         Without it a single sample is taken at H.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rx_wire        asynchronous serial input, idle high
//   m_axis_tdata   head-of-FIFO data, LSB = first bit on the line (0 when empty)
//   m_axis_tuser   [0] parity error, [1] framing error for this beat (0 when empty)
//   m_axis_tvalid  FIFO non-empty
//   m_axis_tready  consumer ready
//   fifo_level     current FIFO occupancy (registered)
//   overrun        one-cycle pulse when a completed frame is dropped (FIFO full)
//   rx_busy        receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_axis #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_wire,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [1:0]                    m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic                          rx_busy
);

    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int H          = BIT_PERIOD / 2;
    localparam int CNT_W      = $clog2(BIT_PERIOD);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int EW         = DATA_WIDTH + 2;   // {ferr, perr, data}

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);
    localparam logic [AW:0]      LEVEL_ONE = (AW+1)'(1);
    localparam logic [AW:0]      LEVEL_MAX = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_next;

    // -----------------------------------------------------------------------
    // Input synchroniser and falling-edge detect (reset to idle-high)
    // -----------------------------------------------------------------------
    logic rx_meta, rxs, rxs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so
            // every flop samples the pre-edge value of its neighbour.
            rx_meta <= rx_wire;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    logic fall;
    assign fall = rxs_d & ~rxs;

    // -----------------------------------------------------------------------
    // Bit timing and sampling
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] baud_cnt;
    logic             sample;
    logic             tick;
    logic             bit_end;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_HM1    = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_H      = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(H + 1);

    logic s_hm1, s_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_hm1 <= 1'b1;
            s_h   <= 1'b1;
        end else begin
            if (baud_cnt == CNT_HM1) s_hm1 <= rxs;
            if (baud_cnt == CNT_H)   s_h   <= rxs;
        end
    end

    // Third vote is the live value at H+1, where the decision is taken.
    assign sample = (s_hm1 & s_h) | (s_hm1 & rxs) | (s_h & rxs);
`else
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(H);

    assign sample = rxs;
`endif

    assign tick    = (state != S_IDLE) && (baud_cnt == CNT_DECIDE);
    assign bit_end = (baud_cnt == CNT_LAST);

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    logic [3:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr;
    logic                  ferr;
    logic                  push;
    logic [EW-1:0]         push_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        push       = 1'b0;
        unique case (state)
            S_IDLE: begin
                // Edge, not level: a held break cannot retrigger.
                if (fall) state_next = S_START;
            end
            S_START: begin
                if (tick && sample)  state_next = S_IDLE;   // false start
                else if (bit_end)    state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_idx == LAST_DATA)
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                // Push at the last stop sample and return to idle without
                // waiting for the bit end, so back-to-back frames are caught.
                if (tick && bit_idx == LAST_STOP) begin
                    push       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The final stop sample is folded in combinationally so the pushed entry
    // includes it.
    assign push_word = {ferr | ~sample, perr, shreg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else if (state == S_IDLE) begin
            // Holding the counter at zero in IDLE clears it on entry to START.
            baud_cnt <= '0;
            bit_idx  <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + CNT_ONE;
            unique case (state)
                S_DATA: begin
                    if (tick)    shreg   <= {sample, shreg[DATA_WIDTH-1:1]};
                    if (bit_end) bit_idx <= (bit_idx == LAST_DATA) ? 4'd0 : bit_idx + 4'd1;
                end
                S_PARITY: begin
                    if (tick) perr <= (((^shreg) ^ sample) != PAR_ODD);
                end
                S_STOP: begin
                    if (tick && !sample) ferr    <= 1'b1;
                    if (bit_end)         bit_idx <= bit_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign rx_busy = (state != S_IDLE);

    // -----------------------------------------------------------------------
    // First-word-fall-through receive FIFO
    // -----------------------------------------------------------------------
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           full, empty, pop, wr_en;
    logic [EW-1:0]  head;

    assign full  = (fifo_level == LEVEL_MAX);
    assign empty = (fifo_level == '0);
    assign pop   = !empty && m_axis_tready;
    // When full, a same-cycle pop frees the slot the push writes into.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overrun    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            overrun <= push && full && !pop;
        end
    end

    // NOTE: storage is deliberately not reset; the level/pointers define
    // validity and the outputs are masked to zero when empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? '0 : head[DATA_WIDTH-1:0];
    assign m_axis_tuser  = empty ? '0 : head[EW-1:DATA_WIDTH];

endmodule
